bet_sequencer: RTL and testbench
================================

Name: bet_sequencer

Overview:
- Controller for the roulette betting datapath: owns the bet table, accepts keyboard bets tagged with the Arduino colour, and sequences the round COLLECT -> SPIN -> SETTLE -> clear.
- Sits between the PS/2 decode path (read_data strobe, betOpcode) and the regfile bet/spin inputs.
- Drives the spin level the processor polls, and clears the table once the round has settled.

Parameters:
- MAX_BETS, 12, number of bet slots.
- SPIN_TIMEOUT, 100000000, max cycles in SPIN without spin_done before forced exit.
- SETTLE_CYCLES, 50000000, cycles the table is held after a spin before clearing.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe, new keyboard code decoded.
- bet_opcode  in  6  decoded code: 6'h3F invalid, 6'h3E spin, others are bets.
- color  in  3  Arduino colour; 3'b000 means no colour present.
- clear_bets  in  1  synchronous table clear request.
- spin_done  in  1  processor strobe: wheel result produced.
- bets  out  8*MAX_BETS  slot i at [8i+7:8i] = {color[1:0], opcode}; 0 = empty.
- bet_count  out  $clog2(MAX_BETS+1)  number of stored bets.
- full  out  1  bet_count == MAX_BETS.
- spin  out  1  high throughout SPIN.
- settling  out  1  high throughout SETTLE.
- accept  out  1  one-cycle pulse, bet written.
- reject  out  1  one-cycle pulse, key strobe refused.
- timeout  out  1  sticky; set on SPIN timeout exit, cleared on entering SPIN.

Behaviour:
- Reset (async): state IDLE, all slots 0, bet_count 0, all pulses and flags 0, timers 0.
- States: IDLE (0 bets), COLLECT (>=1 bet), SPIN, SETTLE.
- Bet acceptance:
  - Condition: key_valid=1, opcode not 3F/3E, color != 0, state IDLE/COLLECT, not full, clear_bets=0.
  - Slot[bet_count] <= {color[1:0], opcode}; bet_count+1.
  - accept pulses the next cycle, together with the visible update.
  - IDLE -> COLLECT.
- Spin key (3E):
  - In COLLECT: -> SPIN next cycle; spin=1; spin timer reset to 0; timeout cleared.
  - In IDLE: reject.
- Reject pulse (one cycle, registered): any key_valid not accepted and not a valid spin.
  - Covers: opcode 3F, color 0, full, state SPIN/SETTLE, IDLE spin, key with clear_bets.
- clear_bets:
  - In IDLE/COLLECT: all slots 0, count 0, -> IDLE next cycle; takes priority over a same-cycle key.
  - Ignored in SPIN/SETTLE.
- SPIN:
  - Table frozen.
  - spin_done=1 -> SETTLE.
  - Else timer reaching SPIN_TIMEOUT-1 -> SETTLE, timeout=1.
  - spin_done and timer expiry in the same cycle: treated as spin_done, timeout stays 0.
  - spin deasserts on the transition cycle.
- SETTLE:
  - settling=1; table held for exactly SETTLE_CYCLES cycles.
  - Then, in one cycle: all slots 0, count 0, -> IDLE.
  - spin_done in SETTLE is ignored.
- Full: at count MAX_BETS, further bets are rejected; spin is still accepted.
- Reset mid-SPIN/SETTLE: immediate return to reset values; no partial clear.
- Counters: saturating/terminal compare only, no wrap-around.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BET_DUP_REJECT_EN.
- Defined: a bet whose {color[1:0], opcode} equals any occupied slot is rejected (reject pulse, no write, count unchanged). Compare runs in parallel over all slots in the strobe cycle; latency is unchanged.
- Undefined: duplicates are stored like any other bet.

Test Plan:
- Reset, then key_valid with opcode 6'h05, color 3'b001 -> accept pulse, slot0 = 8'h45, bet_count=1, state COLLECT.
- Thirteen valid bets (opcodes 1..13, color 3'b010) -> first 12 accepted, slot11 = 8'h8C, full=1, 13th gives reject with table unchanged.
- 2 bets, then opcode 3E -> spin=1 next cycle. Bet key during SPIN -> reject. spin_done -> SETTLE. After SETTLE_CYCLES (bench override 8): bets all 0, count 0, IDLE, spin=0.
- SPIN_TIMEOUT=16, spin with no spin_done -> exit after 16 cycles, timeout=1. Next spin clears timeout.
- Opcode 3E in IDLE; opcode 3F; color 0 -> reject pulse each time, count stays 0. clear_bets with 3 bets plus same-cycle key -> count 0, reject.
- BET_DUP_REJECT_EN defined: 6'h07/col1 twice -> second rejected, count=1. Undefined -> count=2. Also assert reset mid-SPIN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bet_sequencer_if.sv
// Bet sequencer bus: keyboard/processor inputs and the bet table / round status outputs.
// master = the side driving keys and strobes, slave = bet_sequencer.
interface bet_sequencer_if #(
  parameter int MAX_BETS = 12
);
  localparam int CW = $clog2(MAX_BETS + 1);

  logic                    key_valid;
  logic [5:0]              bet_opcode;
  logic [2:0]              color;
  logic                    clear_bets;
  logic                    spin_done;
  logic [8*MAX_BETS-1:0]   bets;
  logic [CW-1:0]           bet_count;
  logic                    full;
  logic                    spin;
  logic                    settling;
  logic                    accept;
  logic                    reject;
  logic                    timeout;

  modport master (
    output key_valid, bet_opcode, color, clear_bets, spin_done,
    input  bets, bet_count, full, spin, settling, accept, reject, timeout
  );

  modport slave (
    input  key_valid, bet_opcode, color, clear_bets, spin_done,
    output bets, bet_count, full, spin, settling, accept, reject, timeout
  );
endinterface

// File: rtl/bet_sequencer.sv
// Roulette bet sequencer: owns the bet table and runs the round
// IDLE/COLLECT -> SPIN -> SETTLE -> clear. All outputs are registered.
// Optional: define BET_DUP_REJECT_EN to refuse a bet identical to a stored one.
module bet_sequencer #(
  parameter int MAX_BETS      = 12,
  parameter int SPIN_TIMEOUT  = 100000000,
  parameter int SETTLE_CYCLES = 50000000
) (
  input logic           clock,
  input logic           reset,
  bet_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_BETS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SPIN, SETTLE} state_t;

  state_t                     state, state_n;
  logic [31:0]                timer;
  logic [MAX_BETS-1:0][7:0]   slots;
  logic [CW-1:0]              cnt, cnt_n;
  logic                       full_q, spin_q, settle_q, acc_q, rej_q, to_q;

  logic       is_spin, in_collect_phase, bet_ok, spin_ok, key_rej, dup;
  logic       wr, clr, to_set;
  logic [7:0] new_slot;

  assign new_slot         = {bus.color[1:0], bus.bet_opcode};
  assign is_spin          = bus.bet_opcode == 6'h3E;
  assign in_collect_phase = (state == IDLE) || (state == COLLECT);

`ifdef BET_DUP_REJECT_EN
  // Parallel match of the incoming bet against every occupied slot
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < MAX_BETS; i++)
      if ((CW'(i) < cnt) && (slots[i] == new_slot)) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

  assign bet_ok  = bus.key_valid && !is_spin && (bus.bet_opcode != 6'h3F) &&
                   (bus.color != 3'b000) && in_collect_phase && !full_q &&
                   !bus.clear_bets && !dup;
  assign spin_ok = bus.key_valid && is_spin && (state == COLLECT) && !bus.clear_bets;
  assign key_rej = bus.key_valid && !bet_ok && !spin_ok;

  // Next-state and table-control decode
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    clr     = 1'b0;
    to_set  = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (bus.clear_bets) begin
          clr     = 1'b1;
          state_n = IDLE;
        end else if (spin_ok) begin
          state_n = SPIN;
        end else if (bet_ok) begin
          wr      = 1'b1;
          state_n = COLLECT;
        end
      end
      SPIN: begin
        // spin_done wins over a same-cycle expiry, so timeout stays clear
        if (bus.spin_done) begin
          state_n = SETTLE;
        end else if (timer == 32'(SPIN_TIMEOUT - 1)) begin
          state_n = SETTLE;
          to_set  = 1'b1;
        end
      end
      SETTLE: begin
        if (timer == 32'(SETTLE_CYCLES - 1)) begin
          clr     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n = cnt;
    if (clr)     cnt_n = '0;
    else if (wr) cnt_n = cnt + CW'(1);
  end

  // State register and phase timer (restarts at 0 on every state change)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)                     timer <= '0;
      else if (state == SPIN || state == SETTLE) timer <= timer + 32'd1;
    end
  end

  // Bet table: append at slot[cnt], or wipe the whole table
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slots <= '0;
      cnt   <= '0;
    end else begin
      cnt <= cnt_n;
      for (int i = 0; i < MAX_BETS; i++) begin
        if (clr)                         slots[i] <= 8'h00;
        else if (wr && (cnt == CW'(i)))  slots[i] <= new_slot;
      end
    end
  end

  // Registered status, pulses and sticky timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q   <= 1'b0;
      spin_q   <= 1'b0;
      settle_q <= 1'b0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      full_q   <= cnt_n == CW'(MAX_BETS);
      spin_q   <= state_n == SPIN;
      settle_q <= state_n == SETTLE;
      acc_q    <= wr;
      rej_q    <= key_rej;
      if (spin_ok)     to_q <= 1'b0;
      else if (to_set) to_q <= 1'b1;
    end
  end

  assign bus.bets      = slots;
  assign bus.bet_count = cnt;
  assign bus.full      = full_q;
  assign bus.spin      = spin_q;
  assign bus.settling  = settle_q;
  assign bus.accept    = acc_q;
  assign bus.reject    = rej_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_bet_sequencer.sv
// Directed bench for bet_sequencer (SPIN_TIMEOUT=16, SETTLE_CYCLES=8).
module tb_bet_sequencer;
  localparam int MB = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  bet_sequencer_if #(.MAX_BETS(MB)) bus ();

  bet_sequencer #(.MAX_BETS(MB), .SPIN_TIMEOUT(16), .SETTLE_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // One-cycle key strobe; returns at the negedge after the capturing edge
  task automatic send(input logic [5:0] op, input logic [2:0] col, input logic clr);
    @(negedge clock);
    bus.key_valid  = 1'b1;
    bus.bet_opcode = op;
    bus.color      = col;
    bus.clear_bets = clr;
    @(negedge clock);
    bus.key_valid  = 1'b0;
    bus.clear_bets = 1'b0;
    bus.bet_opcode = 6'h00;
    bus.color      = 3'b000;
  endtask

  task automatic pulse_done();
    @(negedge clock);
    bus.spin_done = 1'b1;
    @(negedge clock);
    bus.spin_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_chk++;
    if ({bus.bets, bus.bet_count, bus.full, bus.spin, bus.settling,
         bus.accept, bus.reject, bus.timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got count=%0d bets=%h, required all zero", bus.bet_count, bus.bets);
    end
    do_reset();
  endtask

  task automatic test_first_bet();
    do_reset();
    send(6'h05, 3'b001, 1'b0);
    n_chk++;
    if (bus.accept !== 1'b1 || bus.bets[7:0] !== 8'h45 || bus.bet_count !== 4'd1) begin
      n_fail++;
      $display("FAIL first_bet: got acc=%b slot0=%h cnt=%0d, required 1 45 1", bus.accept, bus.bets[7:0], bus.bet_count);
    end
    @(negedge clock);
    n_chk++;
    if (bus.accept !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_one_cycle: got %b, required 0", bus.accept);
    end
  endtask

  task automatic test_full();
    logic [8*MB-1:0] snap;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send(6'(i), 3'b010, 1'b0);
      n_chk++;
      if (bus.accept !== 1'b1 || bus.bet_count !== 4'(i)) begin
        n_fail++;
        $display("FAIL fill_bet_%0d: got acc=%b cnt=%0d, required 1 %0d", i, bus.accept, bus.bet_count, i);
      end
    end
    n_chk++;
    if (bus.bets[95:88] !== 8'h8C || bus.bets[7:0] !== 8'h81 || bus.full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_table: got slot11=%h slot0=%h full=%b, required 8c 81 1", bus.bets[95:88], bus.bets[7:0], bus.full);
    end
    snap = bus.bets;
    send(6'd13, 3'b010, 1'b0);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.accept !== 1'b0 || bus.bet_count !== 4'd12 || bus.bets !== snap) begin
      n_fail++;
      $display("FAIL bet_when_full: got rej=%b acc=%b cnt=%0d, required 1 0 12 table unchanged", bus.reject, bus.accept, bus.bet_count);
    end
    send(6'h3E, 3'b000, 1'b0);
    n_chk++;
    if (bus.spin !== 1'b1 || bus.reject !== 1'b0) begin
      n_fail++;
      $display("FAIL spin_when_full: got spin=%b rej=%b, required 1 0", bus.spin, bus.reject);
    end
  endtask

  task automatic test_spin_settle();
    do_reset();
    send(6'h01, 3'b001, 1'b0);
    send(6'h02, 3'b001, 1'b0);
    send(6'h3E, 3'b000, 1'b0);
    n_chk++;
    if (bus.spin !== 1'b1 || bus.reject !== 1'b0) begin
      n_fail++;
      $display("FAIL spin_enter: got spin=%b rej=%b, required 1 0", bus.spin, bus.reject);
    end
    send(6'h03, 3'b001, 1'b0);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.bet_count !== 4'd2) begin
      n_fail++;
      $display("FAIL bet_in_spin: got rej=%b cnt=%0d, required 1 2", bus.reject, bus.bet_count);
    end
    pulse_done();
    n_chk++;
    if (bus.spin !== 1'b0 || bus.settling !== 1'b1 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_enter: got spin=%b settling=%b to=%b, required 0 1 0", bus.spin, bus.settling, bus.timeout);
    end
    repeat (7) @(negedge clock);
    n_chk++;
    if (bus.settling !== 1'b1 || bus.bet_count !== 4'd2) begin
      n_fail++;
      $display("FAIL settle_hold: got settling=%b cnt=%0d, required 1 2", bus.settling, bus.bet_count);
    end
    @(negedge clock);
    n_chk++;
    if (bus.settling !== 1'b0 || bus.bet_count !== 4'd0 || bus.bets !== '0 || bus.spin !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_clear: got settling=%b cnt=%0d bets=%h, required 0 0 0", bus.settling, bus.bet_count, bus.bets);
    end
    // Back in IDLE: a spin key must now be refused
    send(6'h3E, 3'b000, 1'b0);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.spin !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_settle: got rej=%b spin=%b, required 1 0", bus.reject, bus.spin);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(6'h04, 3'b011, 1'b0);
    send(6'h3E, 3'b000, 1'b0);
    repeat (15) @(negedge clock);
    n_chk++;
    if (bus.spin !== 1'b1 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL spin_16th_cycle: got spin=%b to=%b, required 1 0", bus.spin, bus.timeout);
    end
    @(negedge clock);
    n_chk++;
    if (bus.spin !== 1'b0 || bus.timeout !== 1'b1 || bus.settling !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_exit: got spin=%b to=%b settling=%b, required 0 1 1", bus.spin, bus.timeout, bus.settling);
    end
    repeat (8) @(negedge clock);
    n_chk++;
    if (bus.timeout !== 1'b1 || bus.bet_count !== 4'd0 || bus.settling !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_sticky: got to=%b cnt=%0d settling=%b, required 1 0 0", bus.timeout, bus.bet_count, bus.settling);
    end
    send(6'h04, 3'b011, 1'b0);
    send(6'h3E, 3'b000, 1'b0);
    n_chk++;
    if (bus.timeout !== 1'b0 || bus.spin !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_cleared: got to=%b spin=%b, required 0 1", bus.timeout, bus.spin);
    end
  endtask

  task automatic test_rejects();
    do_reset();
    send(6'h3E, 3'b001, 1'b0);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.spin !== 1'b0 || bus.bet_count !== 4'd0) begin
      n_fail++;
      $display("FAIL spin_in_idle: got rej=%b spin=%b cnt=%0d, required 1 0 0", bus.reject, bus.spin, bus.bet_count);
    end
    send(6'h3F, 3'b001, 1'b0);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.bet_count !== 4'd0) begin
      n_fail++;
      $display("FAIL opcode_3f: got rej=%b cnt=%0d, required 1 0", bus.reject, bus.bet_count);
    end
    send(6'h05, 3'b000, 1'b0);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.accept !== 1'b0 || bus.bet_count !== 4'd0) begin
      n_fail++;
      $display("FAIL no_color: got rej=%b acc=%b cnt=%0d, required 1 0 0", bus.reject, bus.accept, bus.bet_count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    send(6'h01, 3'b001, 1'b0);
    send(6'h02, 3'b010, 1'b0);
    send(6'h03, 3'b011, 1'b0);
    send(6'h06, 3'b001, 1'b1);
    n_chk++;
    if (bus.reject !== 1'b1 || bus.accept !== 1'b0 || bus.bet_count !== 4'd0 || bus.bets !== '0) begin
      n_fail++;
      $display("FAIL clear_with_key: got rej=%b acc=%b cnt=%0d bets=%h, required 1 0 0 0", bus.reject, bus.accept, bus.bet_count, bus.bets);
    end
  endtask

  task automatic test_dup();
    do_reset();
    send(6'h07, 3'b001, 1'b0);
    send(6'h07, 3'b001, 1'b0);
`ifdef BET_DUP_REJECT_EN
    n_chk++;
    if (bus.reject !== 1'b1 || bus.bet_count !== 4'd1) begin
      n_fail++;
      $display("FAIL dup_reject: got rej=%b cnt=%0d, required 1 1", bus.reject, bus.bet_count);
    end
`else
    n_chk++;
    if (bus.accept !== 1'b1 || bus.bet_count !== 4'd2 || bus.bets[15:0] !== 16'h4747) begin
      n_fail++;
      $display("FAIL dup_store: got acc=%b cnt=%0d slots=%h, required 1 2 4747", bus.accept, bus.bet_count, bus.bets[15:0]);
    end
`endif
  endtask

  task automatic test_reset_mid_spin();
    do_reset();
    send(6'h09, 3'b001, 1'b0);
    send(6'h3E, 3'b000, 1'b0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.bets, bus.bet_count, bus.full, bus.spin, bus.settling,
         bus.accept, bus.reject, bus.timeout} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_spin: got spin=%b cnt=%0d bets=%h, required all zero", bus.spin, bus.bet_count, bus.bets);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.bet_opcode = 6'h00;
    bus.color      = 3'b000;
    bus.clear_bets = 1'b0;
    bus.spin_done  = 1'b0;
    test_reset();
    test_first_bet();
    test_full();
    test_spin_settle();
    test_timeout();
    test_rejects();
    test_clear();
    test_dup();
    test_reset_mid_spin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
